wb_stage: RTL
=============

Name: wb_stage

Overview:
- Final pipeline stage of the RV64 core; sits directly upstream of the register file.
- Registers the MEM-stage result, aligns and extends load data, and drives the register-file write port.
- Presents a commit record to the test harness.
- Provides a same-cycle forwarding tap for earlier stages, plus cycle and retired-instruction counters.

Parameters:
- XLEN, 64, datapath width
- NREG, 32, architectural register count (index width = 5)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  64  instruction PC
- in_instr  in  32  instruction word
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_is_load  in  1  select load data instead of ALU result
- in_funct3  in  3  load width/sign (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
- in_addr_low  in  3  byte offset within the 64-bit word
- in_result  in  64  ALU/CSR/link result
- in_mem_rdata  in  64  raw aligned doubleword from data memory
- flush  in  1  discard held and incoming instruction
- commit_valid  out  1  commit record valid
- commit_ready  in  1  harness consumes record
- commit_pc  out  64  PC of the committing instruction
- commit_instr  out  32  instruction word of the committing instruction
- wb_en  out  1  register-file write enable
- wb_addr  out  5  register-file write index
- wb_data  out  64  register-file write data
- fwd_valid  out  1  held instruction will write a non-zero rd
- fwd_rd  out  5  forwarding destination
- fwd_data  out  64  forwarding data (same as wb_data)
- cycle_cnt  out  64  cycles since reset
- instret_cnt  out  64  retired instructions

Behaviour:
- Two states:
  - EMPTY (valid_q=0)
  - FULL (valid_q=1)
- Reset (async): valid_q=0 and both counters 0. All outputs are 0 except in_ready=1.
- in_ready = !valid_q || (commit_valid && commit_ready). Combinational, single-entry pipeline register.
- Accept when in_valid && in_ready && !flush. On that edge, capture all in_* fields.
  - Load alignment/extension is done before the register, so the stored data is final.
- Retire is the commit_valid && commit_ready handshake.
  - Retire without accept → EMPTY.
  - Retire and accept in the same cycle → stays FULL with the new instruction (back-to-back, no bubble).
  - No retire and no accept → hold every field.
- commit_valid = valid_q.
- wb_en = valid_q && commit_ready && reg_write_q && (rd_q != 0). The write therefore lands on the retire edge. x0 is never written.
- fwd_valid = valid_q && reg_write_q && (rd_q != 0). It is independent of commit_ready, so stalled data still forwards.
- Load extension uses byte offset k = in_addr_low:
  - LB/LBU: byte k. LH/LHU: halfword at offset k (k[0]=0). LW/LWU: word at offset k (k[1:0]=0). LD: full doubleword.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
  - Misaligned offsets: use the offset masked to the access alignment (k&~(size-1)). Never trap.
  - in_funct3=111: treat as LD.
- Non-load: data = in_result unchanged.
- flush is synchronous. At the next edge valid_q=0 regardless of in_valid or the handshake.
  - A retire in the flush cycle still counts: instret increments, write occurs.
  - An instruction presented in the flush cycle is dropped.
- cycle_cnt increments every edge after reset. instret_cnt increments on each retire handshake. Both wrap modulo 2^64.
- Reset mid-operation: the held instruction is discarded, no write, counters cleared.

Decomposition:
- Package common (shared):
  - wb_in_t struct bundling pc/instr/rd/reg_write/data
  - funct3 load-width localparams (LB..LWU)
  - XLEN constant
- Sub-module load_align (combinational): funct3, addr_low, rdata → extended 64-bit value.
- wb_stage holds the pipeline register, handshake, and counters.

Test Plan:
- Reset, then in_valid with rd=5, reg_write=1, result=0x1234, commit_ready=1 → next cycle commit_valid=1, wb_en=1, wb_addr=5, wb_data=0x1234; after that edge instret_cnt=1.
- LB, addr_low=3, rdata=0x00000000_80FF0000 → wb_data=0xFFFFFFFF_FFFFFF80. Same with LBU → 0x80. LWU, addr_low=4, rdata=0x89ABCDEF_00000000 → 0x89ABCDEF. LW same → 0xFFFFFFFF_89ABCDEF.
- rd=0, reg_write=1 → commit_valid=1, wb_en=0, fwd_valid=0, instret still increments.
- commit_ready=0 for 3 cycles with a held instruction → in_ready=0, fields stable, fwd_valid=1, wb_en=0. Release → one write, one instret.
- Back-to-back stream of 4 instructions, commit_ready=1 → one commit per cycle, no bubbles, instret_cnt=4. Assert flush with a new in_valid → incoming instruction dropped, commit_valid=0 next cycle.
- Assert reset mid-hold → commit_valid=0, cycle_cnt=0, instret_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: datapath widths,
// load funct3 encodings and the pipeline-register payload.
package wb_stage_pkg;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int REG_W = $clog2(NREG);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic [XLEN-1:0]  data;
    } wb_in_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// raw doubleword and sign- or zero-extends it to XLEN.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_low,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] word_sel;

    // Misaligned offsets are masked down to the access size rather than trapping.
    assign byte_sel = rdata[{addr_low, 3'b000} +: 8];
    assign half_sel = rdata[{addr_low[2:1], 4'b0000} +: 16];
    assign word_sel = rdata[{addr_low[2], 5'b00000} +: 32];

    // NOTE: default assignment first so no path through the case leaves data unassigned (no latch).
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data = {{(XLEN-32){word_sel[31]}}, word_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LWU:  data = {{(XLEN-32){1'b0}}, word_sel};
            default: data = rdata;  // LD and the unused 111 encoding
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: single-entry pipeline register with commit handshake,
// register-file write port, forwarding tap and cycle/instret counters.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_reg_write,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [2:0]       in_addr_low,
    input  logic [XLEN-1:0]  in_result,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic             flush,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [XLEN-1:0]  commit_pc,
    output logic [31:0]      commit_instr,
    output logic             wb_en,
    output logic [REG_W-1:0] wb_addr,
    output logic [XLEN-1:0]  wb_data,
    output logic             fwd_valid,
    output logic [REG_W-1:0] fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [63:0]      cycle_cnt,
    output logic [63:0]      instret_cnt
);

    logic            valid_q;
    wb_in_t          entry_q;
    wb_in_t          entry_d;
    logic [XLEN-1:0] load_data;
    logic            retire;
    logic            accept;
    logic            writes_rd;

    wb_stage_load_align u_align (
        .funct3   (in_funct3),
        .addr_low (in_addr_low),
        .rdata    (in_mem_rdata),
        .data     (load_data)
    );

    assign entry_d = '{
        pc:        in_pc,
        instr:     in_instr,
        rd:        in_rd,
        reg_write: in_reg_write,
        data:      in_is_load ? load_data : in_result
    };

    assign retire   = valid_q && commit_ready;
    assign in_ready = !valid_q || retire;
    assign accept   = in_valid && in_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            entry_q     <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (retire)
                instret_cnt <= instret_cnt + 64'd1;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                entry_q <= entry_d;
            end else if (retire) begin
                valid_q <= 1'b0;
            end
        end
    end

    // x0 is hardwired to zero, so it never writes or forwards.
    assign writes_rd = valid_q && entry_q.reg_write && (entry_q.rd != '0);

    assign commit_valid = valid_q;
    assign commit_pc    = entry_q.pc;
    assign commit_instr = entry_q.instr;

    assign wb_en   = writes_rd && commit_ready;
    assign wb_addr = entry_q.rd;
    assign wb_data = entry_q.data;

    assign fwd_valid = writes_rd;
    assign fwd_rd    = entry_q.rd;
    assign fwd_data  = entry_q.data;

endmodule
